// File: rtl/fsbm_pkg.sv
// Shared constants, state encoding and result-field layout for the
// full-search block-matching motion-estimation core.
package fsbm_pkg;

  localparam int unsigned BLK        = 4;
  localparam int unsigned WIN        = 8;
  localparam int unsigned NSRCH      = WIN - BLK + 1;
  localparam int unsigned NCAND      = NSRCH * NSRCH;
  localparam int unsigned NWORDS     = 20;
  localparam int unsigned SERIAL_LEN = 20;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned SAD_W      = PIX_W + 4;
  localparam int unsigned MV_W       = 4;

  // Result word layout: {mvx, mvy, sad}
  localparam int unsigned R_SAD_LSB  = 0;
  localparam int unsigned R_MVY_LSB  = R_SAD_LSB + SAD_W;
  localparam int unsigned R_MVX_LSB  = R_MVY_LSB + MV_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_SEND
  } state_t;

endpackage

// File: rtl/fsbm_sad16.sv
// Combinational sum of absolute differences over two 4x4 pixel blocks,
// built as 16 parallel abs-diffs followed by a balanced adder tree.
module fsbm_sad16
  import fsbm_pkg::*;
(
  input  logic [BLK*BLK*PIX_W-1:0] i_cur,
  input  logic [BLK*BLK*PIX_W-1:0] i_cand,
  output logic [SAD_W-1:0]         o_sad
);

  logic [PIX_W-1:0] w_ad [BLK*BLK];
  logic [PIX_W:0]   w_l1 [8];
  logic [PIX_W+1:0] w_l2 [4];
  logic [PIX_W+2:0] w_l3 [2];

  always_comb begin
    logic [PIX_W-1:0] v_a;
    logic [PIX_W-1:0] v_b;
    v_a = '0;
    v_b = '0;
    for (int k = 0; k < BLK*BLK; k++) begin
      v_a     = i_cur[k*PIX_W +: PIX_W];
      v_b     = i_cand[k*PIX_W +: PIX_W];
      w_ad[k] = (v_a > v_b) ? (v_a - v_b) : (v_b - v_a);
    end
    for (int k = 0; k < 8; k++) w_l1[k] = {1'b0, w_ad[2*k]} + {1'b0, w_ad[2*k+1]};
    for (int k = 0; k < 4; k++) w_l2[k] = {1'b0, w_l1[2*k]} + {1'b0, w_l1[2*k+1]};
    for (int k = 0; k < 2; k++) w_l3[k] = {1'b0, w_l2[2*k]} + {1'b0, w_l2[2*k+1]};
    o_sad = {1'b0, w_l3[0]} + {1'b0, w_l3[1]};
  end

endmodule

// File: rtl/fsbm_me_top.sv
// Full-search motion estimation: load a 4x4 block and 8x8 window, score all
// 25 candidates by SAD, then shift out {mvx, mvy, sad} MSB first.
module fsbm_me_top
  import fsbm_pkg::*;
#(
  parameter int unsigned WORD_WIDETH = PIX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic [4*WORD_WIDETH-1:0] input_raw,
  output logic                     serial20
);

  state_t r_state;
  state_t w_next_state;

  logic [4:0]             r_word;
  logic [4:0]             r_cand;
  logic [4:0]             r_bit;
  logic [2:0]             r_dx;
  logic [2:0]             r_dy;
  logic [2:0]             r_best_dx;
  logic [2:0]             r_best_dy;
  logic [SAD_W-1:0]       r_best_sad;
  logic                   r_serial;

  logic [WORD_WIDETH-1:0] r_cur [BLK][BLK];
  logic [WORD_WIDETH-1:0] r_win [WIN][WIN];

  logic [3:0]                       w_woff;
  logic [BLK*BLK*WORD_WIDETH-1:0]   w_cur_flat;
  logic [BLK*BLK*WORD_WIDETH-1:0]   w_cand_flat;
  logic [SAD_W-1:0]                 w_sad;
  logic                             w_better;
  logic [SERIAL_LEN-1:0]            w_result;

  assign serial20 = r_serial;
  assign w_woff   = 4'(r_word - 5'(BLK));

  // Pixel storage; contents are meaningless outside a completed LOAD
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      if (r_word < 5'(BLK)) begin
        for (int j = 0; j < BLK; j++)
          r_cur[r_word[1:0]][j] <= input_raw[(BLK-1-j)*WORD_WIDETH +: WORD_WIDETH];
      end else begin
        for (int j = 0; j < BLK; j++)
          r_win[w_woff[3:1]][{w_woff[0], 2'(j)}] <= input_raw[(BLK-1-j)*WORD_WIDETH +: WORD_WIDETH];
      end
    end
  end

  // Candidate window selected by the current (dx, dy)
  always_comb begin
    w_cur_flat  = '0;
    w_cand_flat = '0;
    for (int i = 0; i < BLK; i++) begin
      for (int j = 0; j < BLK; j++) begin
        w_cur_flat[(BLK*BLK-1-(i*BLK+j))*WORD_WIDETH +: WORD_WIDETH]  = r_cur[i][j];
        w_cand_flat[(BLK*BLK-1-(i*BLK+j))*WORD_WIDETH +: WORD_WIDETH] =
          r_win[r_dy + 3'(i)][r_dx + 3'(j)];
      end
    end
  end

  fsbm_sad16 u_sad16 (
    .i_cur  (w_cur_flat),
    .i_cand (w_cand_flat),
    .o_sad  (w_sad)
  );

  // Strict compare keeps the earliest candidate on ties
  assign w_better = (r_cand == 5'd0) || (w_sad < r_best_sad);

  always_comb begin
    w_result = '0;
    w_result[R_MVX_LSB +: MV_W]  = MV_W'(r_best_dx) - MV_W'(2);
    w_result[R_MVY_LSB +: MV_W]  = MV_W'(r_best_dy) - MV_W'(2);
    w_result[R_SAD_LSB +: SAD_W] = r_best_sad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    ;
      S_LOAD:    if (r_word == 5'(NWORDS-1))     w_next_state = S_COMPUTE;
      S_COMPUTE: if (r_cand == 5'(NCAND-1))      w_next_state = S_SEND;
      S_SEND:    if (r_bit == 5'(SERIAL_LEN-1))  w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
    if (init) w_next_state = S_LOAD;
  end

  // Counters, best-candidate tracking and the serial output flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_cand     <= '0;
      r_bit      <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_best_dx  <= '0;
      r_best_dy  <= '0;
      r_best_sad <= '0;
      r_serial   <= 1'b0;
    end else begin
      r_serial <= 1'b0;
      if (init) begin
        r_word <= '0;
        r_cand <= '0;
        r_bit  <= '0;
        r_dx   <= '0;
        r_dy   <= '0;
      end else begin
        case (r_state)
          S_LOAD: r_word <= r_word + 5'd1;
          S_COMPUTE: begin
            if (w_better) begin
              r_best_sad <= w_sad;
              r_best_dx  <= r_dx;
              r_best_dy  <= r_dy;
            end
            r_cand <= r_cand + 5'd1;
            if (r_dx == 3'(NSRCH-1)) begin
              r_dx <= '0;
              r_dy <= r_dy + 3'd1;
            end else begin
              r_dx <= r_dx + 3'd1;
            end
          end
          S_SEND: begin
            r_serial <= w_result[5'(SERIAL_LEN-1) - r_bit];
            r_bit    <= r_bit + 5'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsbm_me_top.sv
// Directed bench for fsbm_me_top: expected result frames are queued when a
// dataset is loaded and compared bit-serially when the frame comes out.
module tb_fsbm_me_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic [31:0] input_raw = '0;
  logic        serial20;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  cur [4][4];
  logic [7:0]  win [8][8];
  logic [19:0] exp_q [$];

  fsbm_me_top #(.WORD_WIDETH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .input_raw (input_raw),
    .serial20  (serial20)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference full search over the bench's own arrays
  function automatic logic [19:0] model();
    int best, bdx, bdy, s, d;
    best = 0; bdx = 0; bdy = 0;
    for (int dy = 0; dy < 5; dy++) begin
      for (int dx = 0; dx < 5; dx++) begin
        s = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            d = int'(cur[i][j]) - int'(win[dy+i][dx+j]);
            s += (d < 0) ? -d : d;
          end
        if ((dx == 0 && dy == 0) || s < best) begin
          best = s; bdx = dx; bdy = dy;
        end
      end
    end
    return {4'(bdx - 2), 4'(bdy - 2), 12'(best)};
  endfunction

  function automatic logic [31:0] word_of(int w);
    logic [31:0] v;
    int r, h;
    if (w < 4) begin
      v = {cur[w][0], cur[w][1], cur[w][2], cur[w][3]};
    end else begin
      r = (w - 4) / 2;
      h = ((w - 4) % 2) * 4;
      v = {win[r][h], win[r][h+1], win[r][h+2], win[r][h+3]};
    end
    return v;
  endfunction

  task automatic check_bit(input string tag, input logic expv);
    checks++;
    assert (serial20 === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, serial20, expv);
    end
  endtask

  task automatic set_centre();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) win[r][c] = 8'hFF;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      cur[i][j] = 8'(16 + 4*i + j);
      win[2+i][2+j] = cur[i][j];
    end
  endtask

  task automatic set_corner();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) win[r][c] = 8'(64 + 8*r + c);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      cur[i][j] = 8'(16 + 4*i + j);
      win[i][4+j] = cur[i][j];
    end
  endtask

  task automatic set_tie();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) win[r][c] = 8'hFF;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) cur[i][j] = 8'h00;
  endtask

  task automatic set_random();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) win[r][c] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) cur[i][j] = 8'($urandom_range(0, 255));
  endtask

  // init sampled at the next posedge (T0), then words at T1..T20
  task automatic load_seq();
    init = 1'b1;
    @(posedge clk);
    #1 init = 1'b0;
    for (int w = 0; w < 20; w++) begin
      input_raw = word_of(w);
      @(negedge clk);
      check_bit("load_quiet", 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compute_quiet(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_bit("compute_quiet", 1'b0);
      @(posedge clk);
    end
  endtask

  // Frame bits at T46..T65, then idle at T66
  task automatic recv_frame(input string tag);
    logic [19:0] obs, expv;
    obs = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      obs[19-k] = serial20;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s_queue observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_bit({tag, "_after"}, 1'b0);
  endtask

  task automatic run_one(input string tag);
    load_seq();
    compute_quiet(25);
    recv_frame(tag);
  endtask

  initial begin
    logic [19:0] tv;

    repeat (3) @(posedge clk);
    #1 check_bit("reset", 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      input_raw = $urandom;
      @(negedge clk);
      check_bit("idle", 1'b0);
    end

    set_centre(); exp_q.push_back(20'h00000); run_one("centre");
    set_corner(); exp_q.push_back(20'h2E000); run_one("corner");
    set_tie();    exp_q.push_back(20'hEEFF0); run_one("tie_max");
    set_random(); exp_q.push_back(model());   run_one("random_a");
    set_random(); exp_q.push_back(model());   run_one("random_b");

    // Restart at T30: the first result must never appear
    set_random(); exp_q.push_back(model());
    load_seq();
    compute_quiet(9);
    #1;
    exp_q.delete();
    set_random(); exp_q.push_back(model());
    load_seq();
    compute_quiet(25);
    recv_frame("restart");

    // Async reset while the frame is being shifted out
    set_tie(); tv = 20'hEEFF0; exp_q.push_back(tv);
    load_seq();
    compute_quiet(25);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_bit("send_pre_reset", tv[19-k]);
    end
    #1 rst_n = 1'b0;
    #1 check_bit("async_reset", 1'b0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check_bit("post_reset_idle", 1'b0);
    end

    set_random(); exp_q.push_back(model()); run_one("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsbm_me_top.md
Name: fsbm_me_top

Overview:
- Full-search block-matching motion-estimation core.
- Streams in one 4x4 current block and one 8x8 search window, 4 pixels per word.
- Evaluates all 25 candidate positions and selects the one with minimum SAD.
- Emits the motion vector plus its SAD as a 20-bit serial frame on serial20; sits between the image-word feeder and the serial result sink.

Parameters:
- WORD_WIDETH, 8, pixel width in bits. input_raw width = 4*WORD_WIDETH; SAD width = WORD_WIDETH+4. Only 8 is required; at 8 the serial frame is 20 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init  in  1  start or restart of a load/compute/send sequence, sampled at posedge.
- input_raw  in  32  4 pixels; [31:24] is the leftmost pixel, [7:0] the rightmost.
- serial20  out  1  registered serial result, MSB first; 0 when idle.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all counters, best-SAD and MV registers = 0; serial20 = 0.
- FSM states: IDLE, LOAD, COMPUTE, SEND.
- init=1 at any posedge, in any state, forces LOAD with word counter 0. This aborts any operation in progress; a SEND in progress is cut off and serial20 goes 0.
- Timing is relative to posedge T0, the edge at which init is sampled high.
- LOAD (posedges T1..T20, one word each, no valid strobe):
  - Words 0-3 = current block rows 0-3.
  - Words 4-19 = search window; row r is word 4+2r (pixels 0-3) and word 5+2r (pixels 4-7).
  - init is ignored only in the sense of restarting; init=1 during LOAD restarts.
- COMPUTE (posedges T21..T45, one candidate per cycle):
  - Candidate order: dy 0..4 outer, dx 0..4 inner.
  - SAD(dx,dy) = sum over i,j in 0..3 of |cur[i][j] - win[dy+i][dx+j]|, computed with 16 parallel absolute differences and an adder tree.
  - SAD is unsigned, 12 bits (max 4080, no overflow).
  - First candidate loads best unconditionally. Later candidates replace best only if SAD < best (strict), so ties keep the earliest in raster order.
- Result word R[19:0]:
  - R[19:16] = mvx = dx-2, 4-bit two's complement, range -2..+2.
  - R[15:12] = mvy = dy-2, same format.
  - R[11:0] = best SAD.
- SEND: serial20 is driven with R[19-k] from posedge T46+k, k=0..19. At posedge T66 the FSM returns to IDLE and serial20=0.
- serial20 is always a flop output with no combinational path from inputs.
- IDLE: holds; serial20=0; input_raw is ignored.
- Reset asserted mid-operation: immediate return to the reset state; pixel storage contents are don't-care.

Decomposition:
- Package fsbm_pkg:
  - BLK=4, WIN=8, NCAND=25, NWORDS=20, SERIAL_LEN=20.
  - State enum.
  - Result field offsets.
- Sub-module fsbm_sad16: combinational SAD of two 4x4 pixel arrays (16 abs-diffs plus adder tree), 12-bit output.
- Top: holds storage, FSM, candidate mux/compare, and the serial shifter.

Test Plan:
- Reset then idle: hold rst_n=0 then 1 with init=0 for 100 cycles -> serial20 stays 0.
- Exact match at centre: current block = window pixels at offset (2,2), window elsewhere 0xFF, block values 0x10..0x1F -> R = mvx 0, mvy 0, SAD 0; serial 0000_0000_000000000000.
- Exact match at corner: block placed at window offset (4,0), the rest of the window random but no duplicate -> mvx=+2 (0010), mvy=-2 (1110), SAD=0; frame bits observed at T46..T65.
- Tie and maximum: current block all 0x00, window all 0xFF -> every SAD is 4080; first candidate wins; R = mvx 1110, mvy 1110, SAD 0xFF0.
- Restart: assert init again at T30 (mid-COMPUTE) with a new dataset -> the first result is never emitted; the second result's frame starts at T30+46.
- Async reset mid-SEND: drop rst_n at T50 -> serial20=0 immediately (no clock needed); after release, the FSM idles until the next init.
